// File: rtl/uart_tx_serializer_if.sv
// Payload handshake between a frame source and the UART transmit serializer.
// The source offers din with its parity settings; the serializer accepts while idle.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic                 parity_en;
  logic                 parity_odd;

  modport master (
    output din,
    output din_valid,
    output parity_en,
    output parity_odd,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    input  parity_en,
    input  parity_odd,
    output din_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first data, optional parity from an external
// running-parity stage, then stop bits. All line and strobe outputs are registered.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned CLK_PER_BIT = 16,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_serializer_if.slave in_if,
  output logic                par_clr,
  output logic                par_odd,
  output logic                par_we,
  output logic                par_din,
  input  logic                par_value,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned BaudW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  // DATA_BITS >= 5 guarantees room for the stop-bit index as well.
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pen_q, pen_d, podd_q, podd_d;
  logic                 tx_q, tx_d, busy_q, busy_d;
  logic                 par_clr_q, par_clr_d, par_odd_q, par_odd_d;
  logic                 par_we_q, par_we_d, par_din_q, par_din_d;
  logic                 accept, bit_end;

  assign in_if.din_ready = (state_q == StIdle);
  assign accept          = (state_q == StIdle) && in_if.din_valid;
  assign bit_end         = (baud_q == BaudW'(CLK_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      par_clr_q <= 1'b0;
      par_odd_q <= 1'b0;
      par_we_q  <= 1'b0;
      par_din_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      par_clr_q <= par_clr_d;
      par_odd_q <= par_odd_d;
      par_we_q  <= par_we_d;
      par_din_q <= par_din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    baud_d  = (state_q == StIdle || bit_end) ? '0 : baud_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        bit_d = '0;
        if (accept) begin
          state_d = StStart;
          data_d  = in_if.din;
          pen_d   = in_if.parity_en;
          podd_d  = in_if.parity_odd;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = pen_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == BitW'(STOP_BITS - 1)) state_d = StIdle;
          else                               bit_d   = bit_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so the registered line changes on the
  // same edge as the state, keeping every bit exactly CLK_PER_BIT cycles wide.
  always_comb begin
    tx_d      = 1'b1;
    busy_d    = (state_d != StIdle);
    par_clr_d = 1'b0;
    par_odd_d = 1'b0;
    par_we_d  = 1'b0;
    par_din_d = 1'b0;
    unique case (state_d)
      StStart: begin
        tx_d = 1'b0;
        if (state_q == StIdle) begin
          par_clr_d = 1'b1;
          par_odd_d = podd_d;
        end
      end
      StData: begin
        tx_d = data_q[bit_d];
        if (baud_d == '0) begin
          par_we_d  = 1'b1;
          par_din_d = data_q[bit_d];
        end
      end
      // Running parity is settled by the end of the last data bit; latch it on entry.
      StParity: tx_d = (state_q == StParity) ? tx_q : par_value;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign par_clr = par_clr_q;
  assign par_odd = par_odd_q;
  assign par_we  = par_we_q;
  assign par_din = par_din_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits) with a parity-stage
// model; stimulus pushes expected frames, a monitor per instance checks each frame.
module tb_uart_tx_serializer;
  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 8;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic        podd;
    logic        b2b;
    logic        abort;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_BITS(DW)) if_a ();
  uart_tx_serializer_if #(.DATA_BITS(DW)) if_b ();

  logic tx_a, busy_a, clr_a, odd_a, we_a, pdin_a, pv_a;
  logic tx_b, busy_b, clr_b, odd_b, we_b, pdin_b, pv_b;

  uart_tx_serializer #(.DATA_BITS(DW), .CLK_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_if(if_a.slave), .par_clr(clr_a), .par_odd(odd_a),
    .par_we(we_a), .par_din(pdin_a), .par_value(pv_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_serializer #(.DATA_BITS(DW), .CLK_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_if(if_b.slave), .par_clr(clr_b), .par_odd(odd_b),
    .par_we(we_b), .par_din(pdin_b), .par_value(pv_b), .tx(tx_b), .busy(busy_b)
  );

  // Downstream serial parity stage.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pv_a <= 1'b0;
    else if (clr_a) pv_a <= odd_a;
    else if (we_a)  pv_a <= pv_a ^ pdin_a;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pv_b <= 1'b0;
    else if (clr_b) pv_b <= odd_b;
    else if (we_b)  pv_b <= pv_b ^ pdin_b;
  end

  logic tx_w [2], busy_w [2], clr_w [2], odd_w [2], we_w [2], rdy_w [2], acc_w [2];
  always_comb begin
    tx_w[0] = tx_a;   tx_w[1] = tx_b;
    busy_w[0] = busy_a; busy_w[1] = busy_b;
    clr_w[0] = clr_a; clr_w[1] = clr_b;
    odd_w[0] = odd_a; odd_w[1] = odd_b;
    we_w[0] = we_a;   we_w[1] = we_b;
    rdy_w[0] = if_a.din_ready; rdy_w[1] = if_b.din_ready;
    acc_w[0] = if_a.din_valid && if_a.din_ready;
    acc_w[1] = if_b.din_valid && if_b.din_ready;
  end

  frame_t sb_a [$];
  frame_t sb_b [$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [DW-1:0] d, input logic pen,
                          input logic pbit, input logic podd, input int stops,
                          input logic b2b, input logic abort);
    frame_t e;
    e.bits = '1;
    e.bits[0] = 1'b0;
    for (int i = 0; i < int'(DW); i++) e.bits[1+i] = d[i];
    e.nbits = 1 + int'(DW) + stops;
    if (pen) begin
      e.bits[1+DW] = pbit;
      e.nbits++;
    end
    e.podd = podd;
    e.b2b = b2b;
    e.abort = abort;
    if (k == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  task automatic mon(input int k);
    frame_t e;
    logic cyc_tx [0:63];
    int len, nwe, nclr, bad;
    logic odd_seen, overlap, rdy_hi, aborted, nxt;
    forever begin
      if (acc_w[k] !== 1'b1) begin
        @(negedge clk);
        continue;
      end
      len = 0; nwe = 0; nclr = 0; odd_seen = 1'b0; overlap = 1'b0;
      rdy_hi = 1'b0; aborted = 1'b0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          aborted = 1'b1;
          break;
        end
        if (busy_w[k] !== 1'b1) break;
        if (len < 64) cyc_tx[len] = tx_w[k];
        if (we_w[k]) nwe++;
        if (clr_w[k]) begin
          nclr++;
          odd_seen = odd_w[k];
        end
        if (we_w[k] && clr_w[k]) overlap = 1'b1;
        if (rdy_w[k]) rdy_hi = 1'b1;
        len++;
        if (len >= 100) break;
      end
      nxt = acc_w[k];
      if ((k == 0 && sb_a.size() == 0) || (k == 1 && sb_b.size() == 0)) begin
        check("sb_unexpected_frame", 1, 0);
        continue;
      end
      e = (k == 0) ? sb_a.pop_front() : sb_b.pop_front();
      if (aborted) begin
        check("frame_aborted_expected", 1, 32'(e.abort));
        continue;
      end
      check("frame_not_aborted", 0, 32'(e.abort));
      check("frame_len", len, e.nbits * int'(CPB));
      bad = 0;
      for (int c = 0; c < len && c < 64; c++)
        if (cyc_tx[c] !== e.bits[c / int'(CPB)]) bad++;
      check("tx_bad_cycles", bad, 0);
      check("par_we_pulses", nwe, DW);
      check("par_clr_pulses", nclr, 1);
      check("par_odd_seed", 32'(odd_seen), 32'(e.podd));
      check("we_clr_overlap", 32'(overlap), 0);
      check("din_ready_in_frame", 32'(rdy_hi), 0);
      check("tx_idle_after", 32'(tx_w[k]), 1);
      check("b2b_accept", 32'(nxt), 32'(e.b2b));
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic drive(input int k, input logic v, input logic [DW-1:0] d,
                       input logic pen, input logic podd);
    if (k == 0) begin
      if_a.din_valid = v; if_a.din = d; if_a.parity_en = pen; if_a.parity_odd = podd;
    end else begin
      if_b.din_valid = v; if_b.din = d; if_b.parity_en = pen; if_b.parity_odd = podd;
    end
  endtask

  task automatic send(input int k, input logic [DW-1:0] d, input logic pen,
                      input logic podd, input bit keep);
    int w;
    @(posedge clk); #1;
    drive(k, 1'b1, d, pen, podd);
    w = 0;
    @(negedge clk);
    while (!rdy_w[k] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait_bound", 32'(w >= 200), 0);
    @(posedge clk); #1;
    if (!keep) begin
      if (k == 0) if_a.din_valid = 1'b0;
      else        if_b.din_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int w;
    w = 0;
    @(negedge clk);
    while (busy_w[k] !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait_bound", 32'(w >= 200), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 1);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ready", 32'(if_a.din_ready), 1);
    check("rst_we_clr", {30'd0, we_a, clr_a}, 0);
    check("rst_din_odd", {30'd0, pdin_a, odd_a}, 0);
    check("rst_b_tx_busy", {30'd0, tx_b, busy_b}, 32'd2);
    reset_n = 1'b1;

    // 0xA5, even parity -> parity bit 0
    push_exp(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    wait_idle(0);
    // 0xA5, odd parity -> parity bit 1
    push_exp(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    wait_idle(0);

    // 0xFF, no parity, two stop bits
    push_exp(1, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    send(1, 8'hFF, 1'b0, 1'b0, 1'b0);
    wait_idle(1);

    // Back-to-back: 0x3C even -> 0, then 0x01 without parity
    push_exp(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    push_exp(0, 8'h01, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    send(0, 8'h3C, 1'b1, 1'b0, 1'b1);
    send(0, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_idle(0);

    // 0x96 odd -> parity 1, inputs toggled every cycle mid-frame
    push_exp(0, 8'h96, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    send(0, 8'h96, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if_a.din = ~if_a.din;
      if_a.parity_odd = ~if_a.parity_odd;
      if_a.parity_en = ~if_a.parity_en;
    end
    wait_idle(0);
    drive(0, 1'b0, '0, 1'b0, 1'b0);

    // Reset during data bit 3
    push_exp(0, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    send(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx_a), 1);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_strobes", {28'd0, we_a, clr_a, pdin_a, odd_a}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(if_a.din_ready), 1);
    check("post_rst_busy", 32'(busy_a), 0);
    w = 0;
    for (int i = 0; i < 12; i++) begin
      if (we_a) w++;
      @(negedge clk);
    end
    check("post_rst_no_we", w, 0);

    // 0x00 odd -> parity 1
    push_exp(0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    send(0, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_idle(0);

    w = 0;
    while ((sb_a.size() + sb_b.size()) != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("sb_drained", sb_a.size() + sb_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
